// File: rtl/md5_padder.sv
// md5_padder: turns a byte stream into the padded 512-bit MD5 message,
// emitted as little-endian 32-bit words with a valid/ready handshake.
// The message is followed by 0x80, then zero fill, then the 64-bit bit
// length. An extra block is added when the length field does not fit.
module md5_padder #(
    parameter int CNT_W = 61
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_keep,
    input  logic        byte_last,
    output logic        byte_ready,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [3:0]  word_index,
    output logic        block_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PAD    = 3'd2,
        LEN_LO = 3'd3,
        LEN_HI = 3'd4
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;      // message length in bytes
    logic [31:0]        asm_r;        // word under assembly / pending 0x80 word
    logic [3:0]         widx_r;       // index of the next word to present
    logic               first_r;      // asm_r holds the 0x80 word still to emit
    logic [31:0]        word_out_r;
    logic               word_valid_r;
    logic [3:0]         word_index_r;
    logic               block_last_r;
    logic               busy_r;
    logic               done_r;

    logic [1:0]         lane_s;
    logic [31:0]        data_s;
    logic [31:0]        pad_s;
    logic [63:0]        len_s;
    logic               accept_s;
    logic               take_s;

    // Replace one byte lane of a word; lane k is bits [8k+7:8k].
    function automatic logic [31:0] set_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  val);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = val;
            2'd1:    res[15:8]  = val;
            2'd2:    res[23:16] = val;
            2'd3:    res[31:24] = val;
            default: res        = word;
        endcase
        return res;
    endfunction

    // Datapath helpers: byte insertion, 0x80 placement and the bit length.
    always_comb begin
        lane_s   = count_r[1:0];
        data_s   = set_lane(asm_r, lane_s, byte_in);
        len_s    = 64'({count_r, 3'b000});
        accept_s = 1'b0;
        take_s   = word_valid_r & word_ready;
        if (byte_keep) begin
            // Lane 3 with a last byte is handled separately (0x80 spills).
            pad_s = set_lane(data_s, lane_s + 2'd1, 8'h80);
        end else begin
            pad_s = set_lane(asm_r, lane_s, 8'h80);
        end
        if ((state_r == DATA) && !word_valid_r && byte_valid) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Beats are taken only in DATA and only while no word is waiting.
    assign byte_ready = (state_r == DATA) && !word_valid_r;

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            count_r      <= '0;
            asm_r        <= 32'h0000_0000;
            widx_r       <= 4'd0;
            first_r      <= 1'b0;
            word_out_r   <= 32'h0000_0000;
            word_valid_r <= 1'b0;
            word_index_r <= 4'd0;
            block_last_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= DATA;
                        count_r <= '0;
                        asm_r   <= 32'h0000_0000;
                        widx_r  <= 4'd0;
                        first_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end

                DATA: begin
                    if (take_s) begin
                        word_valid_r <= 1'b0;
                    end else if (accept_s) begin
                        if (byte_keep) begin
                            count_r <= count_r + 1'b1;
                        end
                        if (byte_last) begin
                            state_r      <= PAD;
                            word_valid_r <= 1'b1;
                            word_index_r <= widx_r;
                            widx_r       <= widx_r + 4'd1;
                            if (byte_keep && (lane_s == 2'd3)) begin
                                // Full data word now, 0x80 opens the next word.
                                word_out_r <= data_s;
                                asm_r      <= 32'h0000_0080;
                                first_r    <= 1'b1;
                            end else begin
                                word_out_r <= pad_s;
                                first_r    <= 1'b0;
                            end
                        end else if (byte_keep) begin
                            if (lane_s == 2'd3) begin
                                word_out_r   <= data_s;
                                word_valid_r <= 1'b1;
                                word_index_r <= widx_r;
                                widx_r       <= widx_r + 4'd1;
                                asm_r        <= 32'h0000_0000;
                            end else begin
                                asm_r <= data_s;
                            end
                        end
                    end
                end

                PAD: begin
                    if (word_valid_r) begin
                        if (word_ready) begin
                            word_valid_r <= 1'b0;
                        end
                    end else if (first_r) begin
                        word_out_r   <= asm_r;
                        word_valid_r <= 1'b1;
                        word_index_r <= widx_r;
                        widx_r       <= widx_r + 4'd1;
                        first_r      <= 1'b0;
                    end else if (widx_r == 4'd14) begin
                        state_r <= LEN_LO;
                    end else begin
                        word_out_r   <= 32'h0000_0000;
                        word_valid_r <= 1'b1;
                        word_index_r <= widx_r;
                        widx_r       <= widx_r + 4'd1;
                    end
                end

                LEN_LO: begin
                    if (!word_valid_r) begin
                        word_out_r   <= len_s[31:0];
                        word_valid_r <= 1'b1;
                        word_index_r <= 4'd14;
                        widx_r       <= 4'd15;
                        state_r      <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (take_s) begin
                        if (block_last_r) begin
                            // Final word accepted: message complete.
                            word_valid_r <= 1'b0;
                            block_last_r <= 1'b0;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                            state_r      <= IDLE;
                        end else begin
                            // Low length word accepted: follow with the high half.
                            word_out_r   <= len_s[63:32];
                            word_index_r <= 4'd15;
                            widx_r       <= 4'd0;
                            block_last_r <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_r      <= IDLE;
                    word_valid_r <= 1'b0;
                    block_last_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign word_out   = word_out_r;
    assign word_valid = word_valid_r;
    assign word_index = word_index_r;
    assign block_last = block_last_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_md5_padder.sv
// Scoreboard bench for md5_padder: an independent padding model pushes the
// expected words when a message is driven, a monitor pops them on handshake.
module tb_md5_padder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_keep = 1'b0;
    logic        byte_last = 1'b0;
    logic        byte_ready;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [3:0]  word_index;
    logic        block_last;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    bit   bp_en = 1'b0;

    md5_padder dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_keep  (byte_keep),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_index (word_index),
        .block_last (block_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference padding: message, 0x80, zeros, 64-bit bit length (LE).
    task automatic push_expected(input logic [7:0] msg[$]);
        int          len;
        int          nblk;
        int          total;
        logic [63:0] bits;
        logic [7:0]  p[$];
        exp_t        e;
        len   = msg.size();
        nblk  = (len + 9 + 63) / 64;
        total = nblk * 64;
        bits  = 64'(len) * 64'd8;
        for (int j = 0; j < total; j++) begin
            if (j < len)              p.push_back(msg[j]);
            else if (j == len)        p.push_back(8'h80);
            else if (j >= total - 8)  p.push_back(8'((bits >> (8 * (j - (total - 8)))) & 64'hFF));
            else                      p.push_back(8'h00);
        end
        for (int w = 0; w < nblk * 16; w++) begin
            e.w    = {p[4*w+3], p[4*w+2], p[4*w+1], p[4*w]};
            e.idx  = 4'(w % 16);
            e.last = (w == nblk * 16 - 1);
            exp_q.push_back(e);
        end
    endtask

    // Consumer backpressure, changed just after each rising edge.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            word_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshake scoreboard, hold stability, byte_ready, done pulse.
    logic [31:0] held_w;
    logic [3:0]  held_i;
    logic        held_l;
    bit          prev_stall = 1'b0;
    bit          exp_done = 1'b0;
    exp_t        got_e;
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
        end else begin
            check("done", done, exp_done);
            if (done) check("busy_at_done", busy, 1'b0);
            if (done) done_cnt++;
            if (prev_stall) begin
                check("hold_valid", word_valid, 1'b1);
                check("hold_word", word_out, held_w);
                check("hold_index", word_index, held_i);
                check("hold_last", block_last, held_l);
            end
            if (word_valid) check("byte_ready_pending", byte_ready, 1'b0);
            exp_done = 1'b0;
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1'b1, 1'b0);
                end else begin
                    got_e = exp_q.pop_front();
                    check("word", word_out, got_e.w);
                    check("index", word_index, got_e.idx);
                    check("block_last", block_last, got_e.last);
                    exp_done = got_e.last;
                end
            end
            prev_stall = word_valid && !word_ready;
            held_w = word_out;
            held_i = word_index;
            held_l = block_last;
        end
    end

    // Drive one message; kind 0 = 0x41 fill, 1 = ramp, 2 = "abc", 3 = random.
    task automatic send_msg(input int len, input int kind, input int abort_at);
        logic [7:0] msg[$];
        int         nbeats;
        int         i;
        int         guard;
        int         d0;
        bit         acc;
        for (int j = 0; j < len; j++) begin
            case (kind)
                0:       msg.push_back(8'h41);
                1:       msg.push_back(8'(j));
                2:       msg.push_back(8'(8'h61 + 8'(j)));
                default: msg.push_back(8'($urandom_range(0, 255)));
            endcase
        end
        push_expected(msg);
        d0 = done_cnt;
        start = 1'b1;
        @(negedge clock);
        check("busy_before_start", busy, 1'b0);
        @(posedge clock);
        #1;
        start = 1'b0;
        @(negedge clock);
        check("busy_after_start", busy, 1'b1);
        @(posedge clock);
        #1;
        nbeats = (len == 0) ? 1 : len;
        i = 0;
        guard = 0;
        while (i < nbeats && !(abort_at >= 0 && i == abort_at) && guard < 5000) begin
            byte_valid = 1'b1;
            byte_keep  = (len != 0);
            byte_in    = (len != 0) ? msg[i] : 8'h00;
            byte_last  = (i == nbeats - 1);
            @(negedge clock);
            acc = byte_ready;
            @(posedge clock);
            #1;
            if (acc) i++;
            guard++;
        end
        byte_valid = 1'b0;
        byte_keep  = 1'b0;
        byte_last  = 1'b0;
        if (guard >= 5000) check("byte_timeout", 1'b1, 1'b0);
        if (abort_at < 0) begin
            guard = 0;
            while (done_cnt == d0 && guard < 3000) begin
                @(negedge clock);
                guard++;
            end
            check("done_timeout", (done_cnt > d0), 1'b1);
            check("queue_drained", exp_q.size(), 0);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 1'b0);
        check({tag, "_word_out"}, word_out, 32'h0);
        check({tag, "_word_valid"}, word_valid, 1'b0);
        check({tag, "_word_index"}, word_index, 4'h0);
        check({tag, "_block_last"}, block_last, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        byte_valid = 1'b1;              // beat in reset/IDLE must be ignored
        @(negedge clock);
        check_reset_values("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("idle_byte_ready", byte_ready, 1'b0);
        @(posedge clock);
        #1;
        byte_valid = 1'b0;

        send_msg(0, 0, -1);             // empty message
        send_msg(3, 2, -1);             // "abc"
        send_msg(55, 0, -1);            // exactly one block
        send_msg(56, 0, -1);            // length spills into second block
        bp_en = 1'b1;
        send_msg(64, 1, -1);            // ramp under backpressure
        send_msg(63, 3, -1);
        send_msg(121, 3, -1);
        bp_en = 1'b0;

        // Abort after 20 bytes, with start raised alongside reset.
        send_msg(40, 1, 20);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check_reset_values("midrst");
        @(posedge clock);
        #1;
        send_msg(3, 2, -1);             // "abc" again after the abort

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md5_padder.md
# md5_padder

Message-formatting stage in front of the MD5 compression core. Accepts a message as a byte stream after the system reset driver drops `reset`. Emits the RFC 1321 padded message as 32-bit little-endian words, 16 per 512-bit block, with a valid/ready handshake into the MD5 controller. Pads with 0x80, zero fill and a 64-bit bit-length field, and adds an extra block when the length field does not fit.

## Interface
- `CNT_W`, default 61: width of the byte counter. The length field is {count, 3'b000}, zero-extended to 64 bits.

Ports (name, direction, width, meaning):
- `clock`, in, 1: the single clock; everything is on posedge.
- `reset`, in, 1: synchronous, active-high. Clears all state.
- `start`, in, 1: pulse in IDLE begins a new message. Ignored when busy.
- `byte_in`, in, 8: message byte.
- `byte_valid`, in, 1: `byte_in` is valid.
- `byte_keep`, in, 1: beat carries a byte. `byte_keep=0` is legal only with `byte_last=1`; such a beat adds no byte and is used for empty messages.
- `byte_last`, in, 1: final beat of the message.
- `byte_ready`, out, 1: padder accepts a beat this cycle.
- `word_out`, out, 32: padded message word.
- `word_valid`, out, 1: `word_out` is valid.
- `word_ready`, in, 1: consumer accepts the word.
- `word_index`, out, 4: position of `word_out` within its block (0–15).
- `block_last`, out, 1: with `word_valid`, marks word 15 of the final block.
- `busy`, out, 1: a message is in progress.
- `done`, out, 1: one-cycle pulse after the final word is accepted.

## Operation
- **States:** IDLE, DATA, PAD, LEN_LO, LEN_HI.
- **IDLE:**
  - `start` → DATA; clears the byte count and word assembly register.
  - `byte_ready=0`.
- **DATA:**
  - `byte_ready = !word_valid`.
  - A beat is accepted on `byte_valid && byte_ready`.
  - A byte goes into lane count[1:0] of the assembly word: byte k at bits [8k+7:8k]. The count then increments.
  - When lane 3 fills, the word is presented: `word_valid=1`, `word_index=count[5:2]`.
- **Last beat accepted:**
  - The next free lane gets 0x80; remaining lanes get 0x00.
  - If the last byte completed a word, 0x80 sits in lane 0 of the next word. That word is emitted after the data word.
  - Then → PAD.
- **PAD:**
  - Emits zero words until the next word index to emit is 14 in a block, then → LEN_LO.
  - If the 0x80 word occupies index 14 or 15, zero fill runs to word 15 of the current block. It then continues through words 0–13 of one extra block.
- **Length words:**
  - LEN_LO emits bits[31:0] of the bit length.
  - LEN_HI emits bits[63:32] with `block_last=1`.
  - On acceptance of the LEN_HI word → IDLE with `done=1`.
- **Total output:** ceil((L+9)/64) blocks, where L is the byte length.
- **Arithmetic:** the byte counter wraps modulo 2^CNT_W. `word_index` wraps 15→0 between blocks.
- **Handshake:**
  - A word transfers on `word_valid && word_ready`.
  - While `word_valid && !word_ready`, `word_out`, `word_index` and `block_last` hold stable.
- **Reset mid-operation:** any partial word or message is discarded. State → IDLE and all outputs return to reset values.
- **Reset values:** `byte_ready=0`, `word_out=0`, `word_valid=0`, `word_index=0`, `block_last=0`, `busy=0`, `done=0`.

## Timing
- **Byte-to-word latency:** the beat completing a word is accepted in cycle t; `word_valid=1` in t+1.
- **Padding throughput:** one word per cycle while `word_ready=1`. A new word appears the cycle after the previous one is accepted. Zero-bubble streaming is not required; one bubble per word is permitted.
- **`busy`:** rises the cycle after `start` is accepted. Falls the same cycle `done` pulses, which is the cycle after the final handshake.
- **Empty message:** the first word (0x00000080) appears in t+1 after the keep=0 last beat is accepted.
- **Simultaneous `start` and `reset`:** `reset` wins.
- **Beats before `start`:** `byte_valid` in IDLE is not accepted.

## Test plan
- **Empty message:** `start`, then a beat with keep=0, last=1 → 16 words: w0=0x00000080, w1..w15=0, `block_last` on w15, `done` pulse one cycle later.
- **"abc":** bytes 0x61, 0x62, 0x63 with last → w0=0x80636261, w1..w13=0, w14=0x00000018, w15=0; single block.
- **55 bytes of 0x41:** w13=0x80414141, w14=0x000001B8, w15=0; exactly 16 words.
- **56 bytes:** w14=0x00000080 and w15=0 in block 0. Block 1 has w0..w13=0, w14=0x000001C0, w15=0. 32 words total; `block_last` only on word 32.
- **Random `word_ready` backpressure on the 64-byte message 0x00..0x3F:**
  - w0=0x03020100 … w15=0x3F3E3D3C.
  - Block 1: w0=0x00000080, w14=0x00000200.
  - Outputs stable while stalled; `byte_ready=0` while a word is pending.
- **Reset mid-message:** `reset` asserted after byte 20 → all outputs at reset values the next cycle. A fresh "abc" afterwards reproduces the "abc" result exactly.
